// File: rtl/css_mcu0_dmi_req_arbiter.sv
// Round-robin share of the core DM register port between JTAG DMI (port 0) and the SoC mailbox (port 1); optional grant lock under CSS_MCU0_DMI_ARB_LOCK_EN.
// One access in flight: accept -> reg_en next cycle -> rsp pulse 2+RD_LATENCY cycles after accept; ready is low outside IDLE.
module css_mcu0_dmi_req_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [6:0]  req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req0_lock,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [6:0]  req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic        req1_lock,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        reg_en,
  output logic        reg_wr_en,
  output logic [6:0]  reg_wr_addr,
  output logic [31:0] reg_wr_data,
  input  logic [31:0] rd_data
);

  if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_latency
    $error("RD_LATENCY must be in 1..7");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic        port_q, port_d;
  logic        write_q, write_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        any_vld;
  logic        pick1;

`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic holder_vld;

  assign holder_vld = port_q ? req1_valid : req0_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_q <= 1'b0;
    else     lock_q <= lock_d;
  end
`else
  logic unused_lock;
  assign unused_lock = req0_lock | req1_lock;
`endif

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    port_d       = port_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    reg_en       = 1'b0;
    reg_wr_en    = 1'b0;
    any_vld      = req0_valid | req1_valid;
    pick1        = req1_valid & (~req0_valid | ~last_grant_q);
`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
    lock_d = lock_q;
    // A held lock pins arbitration to the holder while it keeps asking
    if (lock_q && holder_vld) begin
      pick1 = port_q;
    end
`endif

    unique case (state_q)
      IDLE: begin
`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
        if (lock_q && !holder_vld) lock_d = 1'b0;
`endif
        if (any_vld) begin
          req0_ready = ~pick1;
          req1_ready = pick1;
          port_d     = pick1;
          write_d    = pick1 ? req1_write : req0_write;
          addr_d     = pick1 ? req1_addr  : req0_addr;
          wdata_d    = pick1 ? req1_wdata : req0_wdata;
`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
          lock_d     = pick1 ? req1_lock  : req0_lock;
`endif
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        reg_en    = 1'b1;
        reg_wr_en = write_q;
        lat_cnt_d = 3'(RD_LATENCY - 1);
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q == 3'd0) begin
          if (port_q) rdata1_d = write_q ? 32'd0 : rd_data;
          else        rdata0_d = write_q ? 32'd0 : rd_data;
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      RESP: begin
        rsp0_valid   = ~port_q;
        rsp1_valid   = port_q;
        last_grant_d = port_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_cnt_q    <= 3'd0;
      port_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= 7'd0;
      wdata_q      <= 32'd0;
      last_grant_q <= 1'b1;
      rdata0_q     <= 32'd0;
      rdata1_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      port_q       <= port_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign reg_wr_addr = addr_q;
  assign reg_wr_data = wdata_q;
  assign rsp0_rdata  = rdata0_q;
  assign rsp1_rdata  = rdata1_q;

endmodule

// File: tb/tb_css_mcu0_dmi_req_arbiter.sv
// Directed bench: three arbiter instances at RD_LATENCY 1, 4 and 7 sharing clock, reset and rd_data.
module tb_css_mcu0_dmi_req_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] rd_data;
  always #5 clk = ~clk;

  logic        r0v [3], r0w [3], r0l [3], r1v [3], r1w [3], r1l [3];
  logic [6:0]  r0a [3], r1a [3];
  logic [31:0] r0d [3], r1d [3];
  logic        q0r [3], q1r [3], s0v [3], s1v [3], ren [3], rwe [3];
  logic [31:0] s0d [3], s1d [3], rwd [3];
  logic [6:0]  rwa [3];

  int n_chk = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    css_mcu0_dmi_req_arbiter #(.RD_LATENCY(g == 0 ? 1 : (g == 1 ? 4 : 7))) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(r0v[g]), .req0_ready(q0r[g]), .req0_write(r0w[g]), .req0_addr(r0a[g]),
      .req0_wdata(r0d[g]), .req0_lock(r0l[g]), .rsp0_valid(s0v[g]), .rsp0_rdata(s0d[g]),
      .req1_valid(r1v[g]), .req1_ready(q1r[g]), .req1_write(r1w[g]), .req1_addr(r1a[g]),
      .req1_wdata(r1d[g]), .req1_lock(r1l[g]), .rsp1_valid(s1v[g]), .rsp1_rdata(s1d[g]),
      .reg_en(ren[g]), .reg_wr_en(rwe[g]), .reg_wr_addr(rwa[g]), .reg_wr_data(rwd[g]),
      .rd_data(rd_data)
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int k, input int p, input logic v, input logic w,
                         input logic [6:0] a, input logic [31:0] d, input logic l);
    if (p == 0) begin
      r0v[k] = v; r0w[k] = w; r0a[k] = a; r0d[k] = d; r0l[k] = l;
    end else begin
      r1v[k] = v; r1w[k] = w; r1a[k] = a; r1d[k] = d; r1l[k] = l;
    end
  endtask

  function automatic logic rdy_of(input int k, input int p);
    return (p == 0) ? q0r[k] : q1r[k];
  endfunction
  function automatic logic rsp_of(input int k, input int p);
    return (p == 0) ? s0v[k] : s1v[k];
  endfunction
  function automatic logic [31:0] rdat_of(input int k, input int p);
    return (p == 0) ? s0d[k] : s1d[k];
  endfunction

  // One access on instance k; rd_data carries junk except in the capture cycle (1+lat).
  task automatic single_access(input int k, input int lat, input int p, input logic wr,
                               input logic [6:0] a, input logic [31:0] wd, input logic [31:0] rv);
    logic [31:0] exp_rd;
    exp_rd = wr ? 32'd0 : rv;
    @(negedge clk);
    set_req(k, p, 1'b1, wr, a, wd, 1'b0);
    rd_data = 32'hDEAD_BEEF;
    #1;
    chk("acc_rdy", {31'd0, rdy_of(k, p)}, 32'd1);
    chk("acc_rdy_other", {31'd0, rdy_of(k, 1 - p)}, 32'd0);
    for (int c = 1; c <= 3 + lat; c++) begin
      @(negedge clk);
      if (c == 1) set_req(k, p, 1'b0, wr, a, wd, 1'b0);
      rd_data = (c == 1 + lat) ? rv : (32'hDEAD_0000 | c);
      #1;
      chk("reg_en", {31'd0, ren[k]}, {31'd0, c == 1});
      if (c == 1) begin
        chk("reg_wr_en", {31'd0, rwe[k]}, {31'd0, wr});
        chk("reg_wr_addr", {25'd0, rwa[k]}, {25'd0, a});
        if (wr) chk("reg_wr_data", rwd[k], wd);
      end
      chk("rsp_vld", {31'd0, rsp_of(k, p)}, {31'd0, c == 2 + lat});
      chk("rsp_vld_other", {31'd0, rsp_of(k, 1 - p)}, 32'd0);
      if (c >= 2 + lat) chk("rsp_rdata", rdat_of(k, p), exp_rd);
    end
  endtask

  initial begin
    int grants, g0, g1, nr0, nr1, cyc, p, p1cnt;
    logic exp_lock [4];

    for (int k = 0; k < 3; k++) begin
      set_req(k, 0, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0);
      set_req(k, 1, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0);
    end
    rd_data = 32'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_reg_en", {31'd0, ren[k]}, 32'd0);
      chk("rst_reg_wr_en", {31'd0, rwe[k]}, 32'd0);
      chk("rst_rsp0", {31'd0, s0v[k]}, 32'd0);
      chk("rst_rsp1", {31'd0, s1v[k]}, 32'd0);
      chk("rst_addr", {25'd0, rwa[k]}, 32'd0);
      chk("rst_rdata0", s0d[k], 32'd0);
    end
    rst = 1'b0;

    single_access(0, 1, 0, 1'b0, 7'h11, 32'd0, 32'hA5A5_0001);
    single_access(0, 1, 1, 1'b1, 7'h10, 32'h8000_0001, 32'hFFFF_FFFF);
    chk("rdata0_hold", s0d[0], 32'hA5A5_0001);

    // Both ports valid continuously, four reads each: strict alternation from p0.
    @(negedge clk);
    set_req(0, 0, 1'b1, 1'b0, 7'h01, 32'd0, 1'b0);
    set_req(0, 1, 1'b1, 1'b0, 7'h02, 32'd0, 1'b0);
    rd_data = 32'h0000_0042;
    grants = 0; g0 = 0; g1 = 0; nr0 = 0; nr1 = 0; cyc = 0;
    while (grants < 8 && cyc < 100) begin
      #1;
      if (s0v[0]) nr0++;
      if (s1v[0]) nr1++;
      chk("alt_dual_rsp", {31'd0, s0v[0] & s1v[0]}, 32'd0);
      if (q0r[0] | q1r[0]) begin
        p = q1r[0] ? 1 : 0;
        chk("alt_dual_rdy", {31'd0, q0r[0] & q1r[0]}, 32'd0);
        chk("alt_grant", p, grants % 2);
        grants++;
        if (p == 1) g1++; else g0++;
      end
      @(negedge clk);
      cyc++;
      if (g0 == 4) r0v[0] = 1'b0;
      if (g1 == 4) r1v[0] = 1'b0;
    end
    chk("alt_grants", grants, 8);
    repeat (6) begin
      #1;
      if (s0v[0]) nr0++;
      if (s1v[0]) nr1++;
      @(negedge clk);
    end
    chk("alt_rsp0_count", nr0, 4);
    chk("alt_rsp1_count", nr1, 4);

    // p1 issues three reads with lock=1,1,0 while p0 joins after the first grant.
`ifdef CSS_MCU0_DMI_ARB_LOCK_EN
    exp_lock = '{1'b1, 1'b1, 1'b1, 1'b0};
`else
    exp_lock = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
    set_req(0, 1, 1'b1, 1'b0, 7'h05, 32'd0, 1'b1);
    grants = 0; p1cnt = 0; cyc = 0;
    while (grants < 4 && cyc < 100) begin
      #1;
      if (q0r[0] | q1r[0]) begin
        p = q1r[0] ? 1 : 0;
        chk("lock_grant", p, {31'd0, exp_lock[grants]});
        grants++;
        if (p == 1) p1cnt++;
      end
      @(negedge clk);
      cyc++;
      r0v[0] = (grants >= 1);
      r1l[0] = (p1cnt < 2);
      r1v[0] = (p1cnt < 3);
    end
    chk("lock_grants", grants, 4);
    r0v[0] = 1'b0;
    r1v[0] = 1'b0;
    repeat (6) @(negedge clk);

    // Fresh instance (last_grant=1 from reset): p0 wins the first tie; both withdraw before accept.
    set_req(2, 0, 1'b1, 1'b0, 7'h01, 32'd0, 1'b0);
    set_req(2, 1, 1'b1, 1'b0, 7'h02, 32'd0, 1'b0);
    #1;
    chk("tie_rdy0", {31'd0, q0r[2]}, 32'd1);
    chk("tie_rdy1", {31'd0, q1r[2]}, 32'd0);
    r0v[2] = 1'b0;
    r1v[2] = 1'b0;

    // Reset in the middle of a RD_LATENCY=4 read.
    @(negedge clk);
    set_req(1, 0, 1'b1, 1'b0, 7'h33, 32'd0, 1'b0);
    @(negedge clk);
    r0v[1] = 1'b0;
    #1;
    chk("mid_reg_en", {31'd0, ren[1]}, 32'd1);
    chk("mid_addr", {25'd0, rwa[1]}, 32'h33);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_reg_en", {31'd0, ren[1]}, 32'd0);
    chk("mid_rst_addr", {25'd0, rwa[1]}, 32'd0);
    chk("mid_rst_rsp0", {31'd0, s0v[1]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rd_data = 32'h5555_0000 | c;
      #1;
      chk("post_rst_no_rsp", {30'd0, s0v[1], s1v[1]}, 32'd0);
      chk("post_rst_no_en", {31'd0, ren[1]}, 32'd0);
    end
    single_access(1, 4, 0, 1'b0, 7'h21, 32'd0, 32'hC0DE_0004);

    // Longest latency: response exactly 9 cycles after accept.
    single_access(2, 7, 1, 1'b0, 7'h22, 32'd0, 32'h1234_5678);
    chk("sweep_rdata0_untouched", s0d[2], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
